// File: rtl/button_debouncer.sv
// Debounces a raw push-button into a clean level plus press/release/long-press/auto-repeat strobes.
// Latency: raw change sampled at edge 1 -> pb_state with pb_down/pb_up at edge 2+2**CNT_WIDTH.
// No backpressure; every strobe is single-cycle. Define DEBOUNCE_REPEAT_EN to build the auto-repeat timer.
module button_debouncer #(
    parameter int CNT_WIDTH     = 16,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic pb_state,
    output logic pb_down,
    output logic pb_up,
    output logic pb_long,
    output logic pb_rpt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_LONG  = 2'd2
    } hold_state_t;

    // One timer width serves both the long-press and the repeat counters.
    localparam int TMR_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] LONG_LAST = TMR_W'(LONG_CYCLES - 1);

    logic                 w_btn_pressed;
    logic [1:0]           r_sync;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_pb_state;
    logic                 r_pb_down;
    logic                 r_pb_up;
    logic                 w_idle;
    logic                 w_cnt_full;
    logic                 w_toggle;

    hold_state_t          r_state;
    hold_state_t          w_state_nxt;
    logic [TMR_W-1:0]     r_hold_cnt;
    logic [TMR_W-1:0]     w_hold_nxt;
    logic                 w_long;

    assign w_btn_pressed = ACTIVE_LOW ? ~button : button;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], w_btn_pressed};
        end
    end

    // Any return to agreement with the synchronised level restarts the stable window.
    assign w_idle     = (r_pb_state == r_sync[1]);
    assign w_cnt_full = &r_cnt;
    assign w_toggle   = ~w_idle & w_cnt_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_pb_state <= 1'b0;
            r_pb_down  <= 1'b0;
            r_pb_up    <= 1'b0;
        end else begin
            r_cnt     <= w_idle ? '0 : r_cnt + CNT_WIDTH'(1);
            r_pb_down <= w_toggle & ~r_pb_state;
            r_pb_up   <= w_toggle & r_pb_state;
            if (w_toggle) begin
                r_pb_state <= ~r_pb_state;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    // Release wins over the long-press threshold landing in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_long      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_hold_nxt = '0;
                if (r_pb_down) begin
                    w_state_nxt = S_PRESS;
                end
            end
            S_PRESS: begin
                if (r_pb_up) begin
                    w_state_nxt = S_IDLE;
                end else if (r_hold_cnt == LONG_LAST) begin
                    w_long      = 1'b1;
                    w_state_nxt = S_LONG;
                end else begin
                    w_hold_nxt = r_hold_cnt + TMR_W'(1);
                end
            end
            S_LONG: begin
                if (r_pb_up) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_hold_nxt  = '0;
            end
        endcase
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam logic [TMR_W-1:0] RPT_LAST = TMR_W'(REPEAT_CYCLES - 1);

    logic [TMR_W-1:0] r_rpt_cnt;
    logic [TMR_W-1:0] w_rpt_nxt;
    logic             w_rpt_hit;

    // The counter sits at zero outside LONG, so the first repeat lands REPEAT_CYCLES after pb_long.
    always_comb begin
        w_rpt_nxt = '0;
        w_rpt_hit = 1'b0;
        if (r_state == S_LONG && !r_pb_up) begin
            if (r_rpt_cnt == RPT_LAST) begin
                w_rpt_hit = 1'b1;
            end else begin
                w_rpt_nxt = r_rpt_cnt + TMR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rpt_cnt <= '0;
        end else begin
            r_rpt_cnt <= w_rpt_nxt;
        end
    end

    assign pb_rpt = w_rpt_hit;
`else
    assign pb_rpt = 1'b0;
`endif

    assign pb_state = r_pb_state;
    assign pb_down  = r_pb_down;
    assign pb_up    = r_pb_up;
    assign pb_long  = w_long;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: sliding-window debounce model plus time-since-press strobe model,
// with directed latency checks for press, bounce, release, long hold, repeat and mid-count reset.
`timescale 1ns/1ps
module tb_button_debouncer;

    localparam int CW  = 2;
    localparam int LC  = 10;
    localparam int RC  = 4;
    localparam int WIN = 1 << CW;
`ifdef DEBOUNCE_REPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic button;
    logic pb_state, pb_down, pb_up, pb_long, pb_rpt;

    int errors = 0;
    int checks = 0;
    int n_down = 0, n_up = 0, n_long = 0, n_rpt = 0;

    // Model: history of normalised samples (index 0 = newest), debounced level, cycles since pb_down.
    bit hist [WIN+1];
    bit m_state;
    int m_since;

    button_debouncer #(
        .CNT_WIDTH    (CW),
        .ACTIVE_LOW   (1'b1),
        .LONG_CYCLES  (LC),
        .REPEAT_CYCLES(RC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .button  (button),
        .pb_state(pb_state),
        .pb_down (pb_down),
        .pb_up   (pb_up),
        .pb_long (pb_long),
        .pb_rpt  (pb_rpt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // The level flips once the last 2**CW synchronised samples all disagree with it.
    always @(posedge clk) begin
        bit all_diff;
        bit e_down, e_up, e_long, e_rpt;
        #1;
        e_down = 1'b0;
        e_up   = 1'b0;
        if (!rst_n) begin
            foreach (hist[k]) hist[k] = 1'b0;
            m_state = 1'b0;
            m_since = 0;
        end else begin
            all_diff = 1'b1;
            for (int k = 1; k <= WIN; k++) begin
                if (hist[k] == m_state) all_diff = 1'b0;
            end
            for (int k = WIN; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = ~button;
            if (all_diff) begin
                m_state = ~m_state;
                e_down  = m_state;
                e_up    = ~m_state;
                m_since = 0;
            end else begin
                m_since++;
            end
        end
        e_long = m_state && (m_since == LC);
        e_rpt  = RPT_EN && m_state && (m_since > LC) && (((m_since - LC) % RC) == 0);
        chk("cycle_outputs", 32'({pb_state, pb_down, pb_up, pb_long, pb_rpt}),
            32'({m_state, e_down, e_up, e_long, e_rpt}));
        if (pb_down === 1'b1) n_down++;
        if (pb_up   === 1'b1) n_up++;
        if (pb_long === 1'b1) n_long++;
        if (pb_rpt  === 1'b1) n_rpt++;
    end

    // sel: 0 down, 1 up, 2 long, 3 rpt. edge_no = index of the edge the strobe appeared, -1 on timeout.
    task automatic wait_strobe(input int sel, input int maxe, output int edge_no);
        edge_no = -1;
        for (int e = 1; e <= maxe; e++) begin
            @(posedge clk);
            #1;
            if ((sel == 0 && pb_down === 1'b1) || (sel == 1 && pb_up === 1'b1) ||
                (sel == 2 && pb_long === 1'b1) || (sel == 3 && pb_rpt === 1'b1)) begin
                edge_no = e;
                break;
            end
        end
    endtask

    initial begin
        int e;
        int d0, u0, l0, r0;
        rst_n  = 1'b0;
        button = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({pb_state, pb_down, pb_up, pb_long, pb_rpt}), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press, then release right away: pb_up lands 6 cycles after pb_down.
        button = 1'b0;
        wait_strobe(0, 30, e);
        chk("press_latency", e, 6);
        chk("press_level", 32'(pb_state), 1);
        @(negedge clk);
        chk("press_no_up", n_up, 0);
        button = 1'b1;
        l0 = n_long;
        r0 = n_rpt;
        wait_strobe(1, 30, e);
        chk("release_latency", e, 6);
        chk("release_level", 32'(pb_state), 0);
        repeat (14) @(negedge clk);
        chk("short_no_long", n_long - l0, 0);
        chk("short_no_rpt", n_rpt - r0, 0);

        // Bounce: low 2, high 1, then steady low.
        d0 = n_down;
        button = 1'b0;
        repeat (2) @(negedge clk);
        button = 1'b1;
        @(negedge clk);
        button = 1'b0;
        wait_strobe(0, 30, e);
        chk("bounce_latency", e, 6);
        @(negedge clk);
        chk("bounce_single_down", n_down - d0, 1);

        // Long hold from the bounced press.
        l0 = n_long;
        r0 = n_rpt;
        wait_strobe(2, 30, e);
        chk("long_latency", e, 10);
`ifdef DEBOUNCE_REPEAT_EN
        for (int k = 0; k < 3; k++) begin
            wait_strobe(3, 30, e);
            chk("rpt_period", e, 4);
        end
        @(negedge clk);
        chk("rpt_count", n_rpt - r0, 3);
`else
        repeat (14) @(negedge clk);
        chk("rpt_disabled", n_rpt - r0, 0);
`endif
        // A 3-cycle release glitch while held must not produce pb_up.
        @(negedge clk);
        u0 = n_up;
        button = 1'b1;
        repeat (3) @(negedge clk);
        button = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_no_up", n_up - u0, 0);
        chk("glitch_level", 32'(pb_state), 1);
        button = 1'b1;
        wait_strobe(1, 30, e);
        chk("long_release_latency", e, 6);
        repeat (4) @(negedge clk);
        chk("long_once", n_long - l0, 1);

        // Release debounced exactly at the long-press threshold suppresses pb_long.
        button = 1'b0;
        wait_strobe(0, 30, e);
        chk("press2_latency", e, 6);
        l0 = n_long;
        repeat (4) @(posedge clk);
        @(negedge clk);
        button = 1'b1;
        wait_strobe(1, 30, e);
        chk("edge_release_latency", e, 6);
        repeat (6) @(negedge clk);
        chk("edge_release_no_long", n_long - l0, 0);

        // Reset while the release count sits at 2, then come out of reset with the button held.
        button = 1'b0;
        wait_strobe(0, 30, e);
        chk("press3_latency", e, 6);
        @(negedge clk);
        button = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        chk("pre_reset_level", 32'(pb_state), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({pb_state, pb_down, pb_up, pb_long, pb_rpt}), 0);
        button = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_strobe(0, 30, e);
        chk("post_reset_press", e, 6);
        @(negedge clk);
        button = 1'b1;
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
